// File: rtl/aes_key_sched_ctrl_if.sv
// Bus bundle for aes_key_sched_ctrl: key-load request, expansion-unit link,
// round-key read port and a debug view of the controller state.
//
// Handshake semantics: start is a request with no ready. It is accepted only
// in the cycle the controller is idle (busy=0 and done=0). It is dropped, not
// queued, otherwise. Completion is the one-cycle done pulse. rd_en/rd_valid
// form a fixed-latency read with no backpressure: rd_valid follows rd_en
// exactly one cycle later, and rd_key holds between reads.
interface aes_key_sched_ctrl_if #(
  parameter int KW = 128
);
  logic          start;
  logic [KW-1:0] key;
  logic          busy;
  logic          done;
  logic          key_valid;
  logic [3:0]    kexp_round_num;
  logic [KW-1:0] kexp_key;
  logic [KW-1:0] kexp_round_key;
  logic          rd_en;
  logic [3:0]    rd_idx;
  logic [KW-1:0] rd_key;
  logic          rd_valid;
  logic [1:0]    state_dbg;

  modport slave (
    input  start, key, kexp_round_key, rd_en, rd_idx,
    output busy, done, key_valid, kexp_round_num, kexp_key, rd_key, rd_valid,
           state_dbg
  );

  modport master (
    output start, key, kexp_round_key, rd_en, rd_idx,
    input  busy, done, key_valid, kexp_round_num, kexp_key, rd_key, rd_valid,
           state_dbg
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller. It steps a one-cycle registered
// key-expansion unit through rounds 0..10 and captures every round key into
// an 11-entry store. The cipher engines read that store by index, in any
// order.
// Optional feature macro: AES_KEY_REUSE_EN. When it is defined, restarting
// with the key already expanded skips the expansion.
module aes_key_sched_ctrl #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input logic                  clk,
  input logic                  rst,
  aes_key_sched_ctrl_if.slave  bus
);

  if (NR != 10) begin : g_nr_check
    $error("aes_key_sched_ctrl supports only NR=10 (AES-128)");
  end

  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e        state_q;
  logic [KW-1:0] key_reg_q;
  logic [3:0]    round_q;
  logic [3:0]    cap_idx_q;
  logic          cap_en_q;
  logic          busy_q;
  logic          done_q;
  logic          key_valid_q;
  logic [KW-1:0] store_q [NR+1];
  logic [KW-1:0] rd_key_q;
  logic          rd_valid_q;
  logic          reuse_hit;

`ifdef AES_KEY_REUSE_EN
  // The store already holds this key's schedule, so expansion can be skipped.
  assign reuse_hit = key_valid_q && (bus.key == key_reg_q);
`else
  assign reuse_hit = 1'b0;
`endif

  // Sequencing FSM: it drives the round number and captures round keys into the store.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_reg_q   <= '0;
      round_q     <= '0;
      cap_idx_q   <= '0;
      cap_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      for (int i = 0; i <= NR; i++) store_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q  <= 1'b0;
          round_q <= '0;
          if (bus.start) begin
            if (reuse_hit) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              key_reg_q   <= bus.key;
              key_valid_q <= 1'b0;
              cap_idx_q   <= '0;
              cap_en_q    <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= EXPAND;
            end
          end
        end
        EXPAND: begin
          if (round_q != LAST) round_q <= round_q + 4'd1;
          // The expansion unit's output lags the round number by one cycle.
          cap_en_q <= 1'b1;
          if (cap_en_q) begin
            store_q[cap_idx_q] <= bus.kexp_round_key;
            cap_idx_q          <= cap_idx_q + 4'd1;
            if (cap_idx_q == LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          key_valid_q <= 1'b1;
          round_q     <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read port: one-cycle latency with no write bypass. Out-of-range indices read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_key_q <= (bus.rd_idx <= LAST) ? store_q[bus.rd_idx] : '0;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.key_valid      = key_valid_q;
  assign bus.kexp_round_num = round_q;
  assign bus.kexp_key       = key_reg_q;
  assign bus.rd_key         = rd_key_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Testbench for aes_key_sched_ctrl. A behavioural AES-128 expansion unit feeds
// the controller. Read responses are checked against a queue of expected keys.
module tb_aes_key_sched_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   done_cnt;
  logic [127:0] exp_q[$];
  logic [127:0] mon_exp;
  logic [127:0] kx_q;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  aes_key_sched_ctrl_if #(.KW(128)) bus ();

  aes_key_sched_ctrl #(.NR(10), .KW(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- reference AES-128 key expansion ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] rk, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    w0 = rk[127:96]; w1 = rk[95:64]; w2 = rk[63:32]; w3 = rk[31:0];
    rot = {w3[23:0], w3[31:24]};
    t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon(r), 24'h0};
    n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] k, input int r);
    logic [127:0] v;
    v = k;
    for (int i = 1; i <= r; i++) v = next_rk(v, 4'(i));
    return v;
  endfunction

  // FIPS-197 Appendix A.1 round keys for KEY_A
  function automatic logic [127:0] fips_rk(input int i);
    case (i)
      0:  return 128'h2b7e151628aed2a6abf7158809cf4f3c;
      1:  return 128'ha0fafe1788542cb123a339392a6c7605;
      2:  return 128'hf2c295f27a96b9435935807a7359f67f;
      3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
      4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
      5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
      7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      8:  return 128'head27321b58dbad2312bf5607f8d292f;
      9:  return 128'hac7766f319fadc2128d12941575c006e;
      10: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      default: return 128'h0;
    endcase
  endfunction

  // Registered expansion unit: it loads on round 0 and otherwise advances one round.
  always @(posedge clk) begin
    if (bus.kexp_round_num == 4'd0) kx_q <= bus.kexp_key;
    else kx_q <= next_rk(kx_q, bus.kexp_round_num);
  end
  assign bus.kexp_round_key = kx_q;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: it counts done pulses and pops one expected value per rd_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
      if (bus.rd_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("rd_unexpected", 128'(bus.rd_valid), 128'h0);
        else begin
          mon_exp = exp_q.pop_front();
          chk("rd_key", bus.rd_key, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_issue(input logic [3:0] idx, input logic [127:0] e);
    bus.rd_en  = 1'b1;
    bus.rd_idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic rd_seq_idle(input logic [3:0] idx, input logic [127:0] e);
    rd_issue(idx, e);
    step();
    bus.rd_en = 1'b0;
  endtask

  // Present start for one cycle. It returns in cycle T+1.
  task automatic start_key(input logic [127:0] k);
    bus.key   = k;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Called in T+1. It checks every cycle of a full expansion through T+14.
  // The optional hooks inject a start pulse, or reads at cycles rd_n and rd_n+1.
  task automatic expand_full(input int pulse_n, input logic [127:0] pulse_key,
                             input int rd_n, input logic [3:0] rd_i,
                             input logic [127:0] e0, input logic [127:0] e1);
    for (int n = 1; n <= 12; n++) begin
      chk("busy_phase", 128'({bus.busy, bus.done, bus.key_valid}), 128'b100);
      chk("round_num", 128'(bus.kexp_round_num), 128'((n <= 11) ? n - 1 : 10));
      bus.rd_en = 1'b0;
      bus.start = 1'b0;
      if (n == pulse_n) begin
        bus.start = 1'b1;
        bus.key   = pulse_key;
      end
      if (n == rd_n) rd_issue(rd_i, e0);
      if (n == rd_n + 1) rd_issue(rd_i, e1);
      step();
    end
    bus.rd_en = 1'b0;
    bus.start = 1'b0;
    chk("done_pulse", 128'({bus.busy, bus.done}), 128'b01);
    step();
    chk("done_clear", 128'({bus.busy, bus.done, bus.key_valid}), 128'b001);
    chk("round_idle", 128'(bus.kexp_round_num), 128'h0);
  endtask

  // ---------------- directed sequence ----------------
  int d0;
  initial begin
    checks = 0; failures = 0; done_cnt = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.key = '0; bus.rd_en = 1'b0; bus.rd_idx = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    chk("rst_flags", 128'({bus.busy, bus.done, bus.key_valid, bus.rd_valid}), 128'h0);
    chk("rst_round", 128'(bus.kexp_round_num), 128'h0);
    chk("rst_state", 128'(bus.state_dbg), 128'h0);
    rd_seq_idle(4'd0, 128'h0);
    rd_seq_idle(4'd10, 128'h0);

    // Full expansion of KEY_A; a start at T+5 with KEY_B must be ignored.
    d0 = done_cnt;
    start_key(KEY_A);
    expand_full(5, KEY_B, -10, 4'd0, 128'h0, 128'h0);
    repeat (2) step();
    chk("single_done", 128'(done_cnt - d0), 128'd1);
    chk("state_idle", 128'(bus.state_dbg), 128'h0);

    // Reverse reads on consecutive cycles, then an out-of-range index
    for (int i = 10; i >= 0; i--) begin
      rd_issue(4'(i), fips_rk(i));
      step();
    end
    rd_issue(4'd12, 128'h0);
    step();
    bus.rd_en = 1'b0;
    repeat (2) step();

    // Restart with the same key
    d0 = done_cnt;
    bus.key   = KEY_A;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
`ifdef AES_KEY_REUSE_EN
    chk("reuse_done", 128'({bus.busy, bus.done, bus.key_valid}), 128'b011);
    step();
    chk("reuse_after", 128'({bus.busy, bus.done, bus.key_valid}), 128'b001);
`else
    expand_full(-10, 128'h0, -10, 4'd0, 128'h0, 128'h0);
`endif
    step();
    chk("same_key_done", 128'(done_cnt - d0), 128'd1);
    rd_seq_idle(4'd1, fips_rk(1));
    rd_seq_idle(4'd10, fips_rk(10));

    // Re-expansion with KEY_B: read entry 3 in its capture cycle, then one cycle later
    start_key(KEY_B);
    expand_full(-10, 128'h0, 5, 4'd3, fips_rk(3), ref_round(KEY_B, 3));
    rd_seq_idle(4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    rd_seq_idle(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    rd_seq_idle(4'd0, KEY_B);

    // Reset during expansion: rst is sampled at the end of T+6
    start_key(KEY_A);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_flags", 128'({bus.busy, bus.done, bus.key_valid}), 128'h0);
    chk("midrst_round", 128'(bus.kexp_round_num), 128'h0);
    chk("midrst_state", 128'(bus.state_dbg), 128'h0);
    rd_seq_idle(4'd0, 128'h0);
    rd_seq_idle(4'd3, 128'h0);
    rd_seq_idle(4'd10, 128'h0);

    // A new start after reset completes normally
    start_key(KEY_A);
    expand_full(-10, 128'h0, -10, 4'd0, 128'h0, 128'h0);
    rd_seq_idle(4'd10, fips_rk(10));
    rd_seq_idle(4'd5, fips_rk(5));

    repeat (3) step();
    chk("queue_drained", 128'(exp_q.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
